// File: rtl/regfile_arb.sv
// regfile_arb: core/debug scheduler for the single-ported register file, with debug aging.
// Optional build macro RFARB_ZERO_REG_EN hardwires register 0 to zero.
module regfile_arb #(
  parameter int AW      = 5,
  parameter int DW      = 32,
  parameter int MAXWAIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_valid,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wd,
  output logic          c_ready,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  input  logic          d_valid,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wd,
  output logic          d_ready,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic [AW-1:0] rf_addr,
  output logic          rf_we,
  output logic [DW-1:0] rf_wd,
  input  logic [DW-1:0] rf_rd,
  output logic          grant
);

  localparam int CW = $clog2(MAXWAIT + 1);
  localparam logic [CW-1:0] WMAX = CW'(MAXWAIT);

  logic [CW-1:0] wcnt_r;
  logic          sel_we_s;
  logic [DW-1:0] rdval_s;
  logic          c_rd_s;
  logic          d_rd_s;
  logic          c_rvalid_r;
  logic          d_rvalid_r;
  logic [DW-1:0] c_rdata_r;
  logic [DW-1:0] d_rdata_r;

  // Grant selection and register-file port mux; an aged debug request beats the core.
  always_comb begin
    c_ready  = 1'b0;
    d_ready  = 1'b0;
    grant    = 1'b0;
    rf_addr  = {AW{1'b0}};
    rf_wd    = {DW{1'b0}};
    sel_we_s = 1'b0;
    if (rst) begin
      c_ready = 1'b0;
      d_ready = 1'b0;
    end else if (d_valid && (wcnt_r == WMAX)) begin
      d_ready = 1'b1;
    end else if (c_valid) begin
      c_ready = 1'b1;
    end else if (d_valid) begin
      d_ready = 1'b1;
    end else begin
      c_ready = 1'b0;
      d_ready = 1'b0;
    end
    grant = d_ready;
    if (c_ready) begin
      rf_addr  = c_addr;
      rf_wd    = c_wd;
      sel_we_s = c_we;
    end else if (d_ready) begin
      rf_addr  = d_addr;
      rf_wd    = d_wd;
      sel_we_s = d_we;
    end else begin
      rf_addr  = {AW{1'b0}};
      rf_wd    = {DW{1'b0}};
      sel_we_s = 1'b0;
    end
  end

`ifdef RFARB_ZERO_REG_EN
  // Register 0 is constant zero: suppress its writes and mask its reads.
  always_comb begin
    rf_we   = 1'b0;
    rdval_s = rf_rd;
    if (rf_addr == {AW{1'b0}}) begin
      rf_we   = 1'b0;
      rdval_s = {DW{1'b0}};
    end else begin
      rf_we   = sel_we_s;
      rdval_s = rf_rd;
    end
  end
`else
  // Address 0 behaves as an ordinary register.
  always_comb begin
    rf_we   = sel_we_s;
    rdval_s = rf_rd;
  end
`endif

  assign c_rd_s = c_valid & c_ready & ~c_we;
  assign d_rd_s = d_valid & d_ready & ~d_we;

  // Debug aging counter: counts lost cycles, cleared on debug issue or withdrawal.
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt_r <= {CW{1'b0}};
    end else if (!d_valid || d_ready) begin
      wcnt_r <= {CW{1'b0}};
    end else if (wcnt_r != WMAX) begin
      wcnt_r <= wcnt_r + CW'(1);
    end
  end

  // Per-requester read response registers; data holds until that requester's next read.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_rvalid_r <= 1'b0;
      d_rvalid_r <= 1'b0;
      c_rdata_r  <= {DW{1'b0}};
      d_rdata_r  <= {DW{1'b0}};
    end else begin
      c_rvalid_r <= c_rd_s;
      d_rvalid_r <= d_rd_s;
      if (c_rd_s) begin
        c_rdata_r <= rdval_s;
      end
      if (d_rd_s) begin
        d_rdata_r <= rdval_s;
      end
    end
  end

  // A response pulse landing in a reset cycle is dropped.
  assign c_rvalid = c_rvalid_r & ~rst;
  assign d_rvalid = d_rvalid_r & ~rst;
  assign c_rdata  = c_rdata_r;
  assign d_rdata  = d_rdata_r;

endmodule

// File: tb/tb_regfile_arb.sv
// Directed bench for regfile_arb: register-file model, read-response scoreboard, immediate assertions.
module tb_regfile_arb;

  logic        clk;
  logic        rst;
  logic        c_valid, c_we, c_ready, c_rvalid;
  logic [4:0]  c_addr;
  logic [31:0] c_wd, c_rdata;
  logic        d_valid, d_we, d_ready, d_rvalid;
  logic [4:0]  d_addr;
  logic [31:0] d_wd, d_rdata;
  logic [4:0]  rf_addr;
  logic        rf_we;
  logic [31:0] rf_wd, rf_rd;
  logic        grant;

  logic [31:0] mem [32];
  logic [31:0] exp_mem [32];
  logic [32:0] sb [$];
  logic [31:0] exp_c, exp_d;
  logic        rd_known;
  int          nvec;
  int          nerr;

  regfile_arb #(.AW(5), .DW(32), .MAXWAIT(4)) dut (
    .clk(clk), .rst(rst),
    .c_valid(c_valid), .c_we(c_we), .c_addr(c_addr), .c_wd(c_wd),
    .c_ready(c_ready), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_valid(d_valid), .d_we(d_we), .d_addr(d_addr), .d_wd(d_wd),
    .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .rf_addr(rf_addr), .rf_we(rf_we), .rf_wd(rf_wd), .rf_rd(rf_rd),
    .grant(grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: preloaded during reset, written on rf_we.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'(i) * 32'h0101_0101;
    end else if (rf_we) begin
      mem[rf_addr] <= rf_wd;
    end
  end
  assign rf_rd = mem[rf_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle; eg = expected issue owner (0 idle, 1 core, 2 debug).
  task automatic step(input logic cv, input logic cwe, input logic [4:0] ca, input logic [31:0] cwd,
                      input logic dv, input logic dwe, input logic [4:0] da, input logic [31:0] dwd,
                      input int eg);
    logic [32:0] e;
    logic        we, xwe;
    logic [4:0]  a;
    logic [31:0] wd, rexp;
    c_valid = cv; c_we = cwe; c_addr = ca; c_wd = cwd;
    d_valid = dv; d_we = dwe; d_addr = da; d_wd = dwd;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e[32]) exp_d = e[31:0];
      else exp_c = e[31:0];
      chk("c_rvalid", {31'd0, c_rvalid}, {31'd0, (!rst && !e[32])});
      chk("d_rvalid", {31'd0, d_rvalid}, {31'd0, (!rst && e[32])});
    end else begin
      chk("c_rvalid_idle", {31'd0, c_rvalid}, 32'd0);
      chk("d_rvalid_idle", {31'd0, d_rvalid}, 32'd0);
    end
    if (rd_known) begin
      chk("c_rdata", c_rdata, exp_c);
      chk("d_rdata", d_rdata, exp_d);
    end
    chk("c_ready", {31'd0, c_ready}, {31'd0, (eg == 1)});
    chk("d_ready", {31'd0, d_ready}, {31'd0, (eg == 2)});
    chk("grant", {31'd0, grant}, {31'd0, (eg == 2)});
    we = (eg == 1) ? cwe : (eg == 2) ? dwe : 1'b0;
    a  = (eg == 1) ? ca  : (eg == 2) ? da  : 5'd0;
    wd = (eg == 1) ? cwd : (eg == 2) ? dwd : 32'd0;
`ifdef RFARB_ZERO_REG_EN
    xwe  = we && (a != 5'd0);
    rexp = (a == 5'd0) ? 32'd0 : exp_mem[a];
`else
    xwe  = we;
    rexp = exp_mem[a];
`endif
    chk("rf_we", {31'd0, rf_we}, {31'd0, xwe});
    chk("rf_addr", {27'd0, rf_addr}, {27'd0, a});
    chk("rf_wd", rf_wd, wd);
    if (eg != 0 && !we) sb.push_back({(eg == 2), rexp});
    if (xwe) exp_mem[a] = wd;
    @(posedge clk);
    #1;
    if (rst) begin
      exp_c = 32'd0;
      exp_d = 32'd0;
      rd_known = 1'b1;
      sb.delete();
    end
  endtask

  initial begin
    nvec = 0; nerr = 0; rd_known = 1'b0;
    exp_c = 32'd0; exp_d = 32'd0;
    for (int i = 0; i < 32; i++) exp_mem[i] = 32'(i) * 32'h0101_0101;
    rst = 1'b1;
    c_valid = 1'b0; c_we = 1'b0; c_addr = 5'd0; c_wd = 32'd0;
    d_valid = 1'b0; d_we = 1'b0; d_addr = 5'd0; d_wd = 32'd0;
    @(posedge clk);
    #1;
    // Requests during reset are ignored.
    step(1'b1, 1'b1, 5'd2, 32'h1, 1'b1, 1'b1, 5'd3, 32'h2, 0);
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 0);
    rst = 1'b0;
    chk("wcnt_after_reset", {29'd0, dut.wcnt_r}, 32'd0);
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 0);

    // Core write r5 then read-after-write.
    step(1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 1'b0, 5'd0, 32'h0, 1);
    step(1'b1, 1'b0, 5'd5, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1);
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 0);

    // r7=0x12, r3=0x34; debug read while core idle, then core read must not disturb d_rdata.
    step(1'b1, 1'b1, 5'd7, 32'h12, 1'b0, 1'b0, 5'd0, 32'h0, 1);
    step(1'b1, 1'b1, 5'd3, 32'h34, 1'b0, 1'b0, 5'd0, 32'h0, 1);
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd7, 32'h0, 2);
    step(1'b1, 1'b0, 5'd3, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1);
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 0);
    chk("d_rdata_kept", d_rdata, 32'h12);
    chk("c_rdata_r3", c_rdata, 32'h34);

    // Continuous contention: period of 4 core issues then 1 debug issue.
    for (int i = 0; i < 15; i++)
      step(1'b1, 1'b0, 5'(i), 32'h0, 1'b1, 1'b0, 5'(20 + (i % 4)), 32'h0, ((i % 5) == 4) ? 2 : 1);
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 0);

    // Debug drops after 3 losses: counter clears and the full wait applies again.
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, 5'd1, 32'h0, 1'b1, 1'b0, 5'd2, 32'h0, 1);
    step(1'b1, 1'b0, 5'd1, 32'h0, 1'b0, 1'b0, 5'd2, 32'h0, 1);
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b0, 5'd1, 32'h0, 1'b1, 1'b0, 5'd4, 32'h0, 1);
    step(1'b1, 1'b0, 5'd1, 32'h0, 1'b1, 1'b0, 5'd4, 32'h0, 2);

    // Alternating requesters with read-after-write on r9.
    step(1'b1, 1'b1, 5'd9, 32'hA5A5_0009, 1'b0, 1'b0, 5'd0, 32'h0, 1);
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd9, 32'h0, 2);
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 0);
    chk("d_rdata_r9", d_rdata, 32'hA5A5_0009);

    // Reset in the cycle after a core read: pulse dropped, state cleared.
    step(1'b1, 1'b0, 5'd5, 32'h0, 1'b1, 1'b0, 5'd6, 32'h0, 1);
    rst = 1'b1;
    step(1'b1, 1'b0, 5'd5, 32'h0, 1'b1, 1'b0, 5'd6, 32'h0, 0);
    rst = 1'b0;
    chk("wcnt_reset_mid", {29'd0, dut.wcnt_r}, 32'd0);
    chk("c_rdata_reset", c_rdata, 32'd0);
    chk("d_rdata_reset", d_rdata, 32'd0);
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 0);

    // Debug write then read of r0.
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 2);
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0, 2);
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 0);
`ifdef RFARB_ZERO_REG_EN
    chk("d_rdata_r0", d_rdata, 32'h0);
`else
    chk("d_rdata_r0", d_rdata, 32'hFFFF_FFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
